// File: rtl/bcd_counter_pkg.sv
// Shared types and constants for the BCD counter family.
package bcd_counter_pkg;

  localparam int unsigned DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] DIGIT_MAX = 4'd9;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } cnt_state_t;

  function automatic logic [DIGIT_W-1:0] clamp_digit(input logic [DIGIT_W-1:0] d);
    return (d > DIGIT_MAX) ? DIGIT_MAX : d;
  endfunction

endpackage

// File: rtl/bcd_digit_down.sv
// One BCD decade of the down counter: loads a clamped digit or decrements on borrow-in.
module bcd_digit_down
  import bcd_counter_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  input  logic               dec,
  input  logic               ld,
  input  logic [DIGIT_W-1:0] ld_val,
  output logic [DIGIT_W-1:0] digit,
  output logic               borrow_out
);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      digit <= '0;
    end else if (ld) begin
      digit <= clamp_digit(ld_val);
    end else if (dec) begin
      digit <= (digit == '0) ? DIGIT_MAX : digit - 4'd1;
    end
  end

  assign borrow_out = dec && (digit == '0);

endmodule

// File: rtl/bcd_down_counter.sv
// Cascaded BCD countdown timer with load, done pulse and optional periodic reload.
// Define BCD_DOWN_RELOAD_EN for periodic mode; default build is one-shot.
module bcd_down_counter
  import bcd_counter_pkg::*;
#(
  parameter int unsigned DIGITS = 2
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      load,
  input  logic [DIGIT_W*DIGITS-1:0] load_value,
  input  logic                      en,
  output logic [DIGIT_W*DIGITS-1:0] q,
  output logic                      zero,
  output logic                      running,
  output logic                      done
);

  localparam int unsigned W = DIGIT_W * DIGITS;

  cnt_state_t     state;
  logic [W-1:0]   reload_q;
  logic [W-1:0]   load_clamped;
  logic [W-1:0]   ld_val;
  logic           ld;
  logic           tick;
  logic           q_is_one;
  logic [DIGITS:0] borrow;

  always_comb begin
    load_clamped = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      load_clamped[i*DIGIT_W +: DIGIT_W] = clamp_digit(load_value[i*DIGIT_W +: DIGIT_W]);
    end
  end

  assign zero     = (q == '0);
  assign q_is_one = (q == W'(1));
  assign running  = (state == RUN);
  assign tick     = running && en && !load;

  // A tick at zero borrows out of every digit; that final borrow is the reload
  // trigger. RUN with q==0 is only reachable in periodic mode.
  assign borrow[0] = tick;
  assign ld        = load || borrow[DIGITS];
  assign ld_val    = load ? load_value : reload_q;

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    bcd_digit_down u_digit (
      .clk       (clk),
      .reset_n   (reset_n),
      .dec       (borrow[i]),
      .ld        (ld),
      .ld_val    (ld_val[i*DIGIT_W +: DIGIT_W]),
      .digit     (q[i*DIGIT_W +: DIGIT_W]),
      .borrow_out(borrow[i+1])
    );
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= IDLE;
      done     <= 1'b0;
      reload_q <= '0;
    end else begin
      done <= 1'b0;
      if (load) begin
        if (load_value != '0) begin
          state    <= RUN;
          reload_q <= load_clamped;
        end else begin
          state <= DONE;
        end
      end else if (tick && q_is_one) begin
        done <= 1'b1;
`ifdef BCD_DOWN_RELOAD_EN
        state <= RUN;
`else
        state <= DONE;
`endif
      end
    end
  end

endmodule

// File: tb/tb_bcd_down_counter.sv
// Self-checking bench for bcd_down_counter (DIGITS=3) against an integer reference model.
module tb_bcd_down_counter;

  localparam int unsigned DIGITS = 3;
  localparam int unsigned W = 4 * DIGITS;
`ifdef BCD_DOWN_RELOAD_EN
  localparam bit PERIODIC = 1'b1;
`else
  localparam bit PERIODIC = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset_n;
  logic         load;
  logic         en;
  logic [W-1:0] load_value;
  logic [W-1:0] q;
  logic         zero;
  logic         running;
  logic         done;

  int checks = 0;
  int errors = 0;

  // Reference model: count as a plain integer, state 0=idle 1=run 2=done
  int m_cnt = 0;
  int m_reload = 0;
  int m_st = 0;
  bit m_done = 1'b0;

  bcd_down_counter #(.DIGITS(DIGITS)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .load      (load),
    .load_value(load_value),
    .en        (en),
    .q         (q),
    .zero      (zero),
    .running   (running),
    .done      (done)
  );

  always #5 clk = ~clk;

  function automatic int bcd_to_int_clamped(input logic [W-1:0] v);
    int acc = 0;
    int p = 1;
    for (int i = 0; i < int'(DIGITS); i++) begin
      int d = int'(v[i*4 +: 4]);
      if (d > 9) d = 9;
      acc += d * p;
      p *= 10;
    end
    return acc;
  endfunction

  function automatic logic [W-1:0] int_to_bcd(input int n);
    logic [W-1:0] r = '0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      r[i*4 +: 4] = 4'(n % 10);
      n = n / 10;
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    if (!reset_n) begin
      m_cnt = 0; m_reload = 0; m_st = 0; m_done = 1'b0;
    end else if (load) begin
      int v = bcd_to_int_clamped(load_value);
      m_done = 1'b0;
      if (v != 0) begin
        m_cnt = v; m_reload = v; m_st = 1;
      end else begin
        m_cnt = 0; m_st = 2;
      end
    end else if (m_st == 1 && en) begin
      m_done = 1'b0;
      if (m_cnt == 1) begin
        m_cnt = 0; m_done = 1'b1;
        m_st = PERIODIC ? 1 : 2;
      end else if (m_cnt == 0) begin
        m_cnt = m_reload;
      end else begin
        m_cnt = m_cnt - 1;
      end
    end else begin
      m_done = 1'b0;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check("q", 32'(q), 32'(int_to_bcd(m_cnt)));
    check("zero", 32'(zero), 32'(m_cnt == 0));
    check("running", 32'(running), 32'(m_st == 1));
    check("done", 32'(done), 32'(m_done));
  endtask

  task automatic drive(input logic rn, input logic ld, input logic [W-1:0] lv, input logic e);
    reset_n = rn; load = ld; load_value = lv; en = e;
  endtask

  initial begin
    int seq [8];
    seq = '{2, 1, 0, 3, 2, 1, 0, 3};

    // Reset dominates simultaneous load and en
    drive(1'b0, 1'b1, 12'h345, 1'b1);
    cycle();
    check("reset_q", 32'(q), 32'h0);
    check("reset_done", 32'(done), 32'h0);

    // IDLE ignores en
    drive(1'b1, 1'b0, '0, 1'b1);
    cycle();
    cycle();

    // Load 12 and count all the way down, then over-tick
    drive(1'b1, 1'b1, 12'h012, 1'b0);
    cycle();
    check("load12", 32'(q), 32'h012);
    drive(1'b1, 1'b0, '0, 1'b1);
    for (int i = 0; i < 12; i++) cycle();
    check("q_at_zero", 32'(q), 32'h000);
    check("done_at_zero", 32'(done), 32'h1);
    cycle();
    cycle();

    // Borrow through two digits in one edge
    drive(1'b1, 1'b1, 12'h100, 1'b0);
    cycle();
    drive(1'b1, 1'b0, '0, 1'b1);
    cycle();
    check("borrow_ripple", 32'(q), 32'h099);

    // Invalid digit clamps; zero load goes DONE with no pulse
    drive(1'b1, 1'b1, 12'h05F, 1'b0);
    cycle();
    check("clamp", 32'(q), 32'h059);
    drive(1'b1, 1'b1, 12'h000, 1'b0);
    cycle();
    check("load_zero_running", 32'(running), 32'h0);
    drive(1'b1, 1'b0, '0, 1'b1);
    for (int i = 0; i < 3; i++) cycle();

    // Load beats a same-cycle tick; reset mid-count
    drive(1'b1, 1'b1, 12'h004, 1'b0);
    cycle();
    drive(1'b1, 1'b0, '0, 1'b1);
    cycle();
    drive(1'b1, 1'b1, 12'h007, 1'b1);
    cycle();
    check("load_wins", 32'(q), 32'h007);
    drive(1'b1, 1'b0, '0, 1'b1);
    for (int i = 0; i < 3; i++) cycle();
    drive(1'b0, 1'b1, 12'h123, 1'b1);
    cycle();
    check("mid_reset_q", 32'(q), 32'h0);
    check("mid_reset_running", 32'(running), 32'h0);

    if (PERIODIC) begin
      drive(1'b1, 1'b1, 12'h003, 1'b0);
      cycle();
      drive(1'b1, 1'b0, '0, 1'b1);
      for (int i = 0; i < 8; i++) begin
        cycle();
        check("periodic_q", 32'(q), 32'(int_to_bcd(seq[i])));
        check("periodic_running", 32'(running), 32'h1);
      end
    end

    // Randomized traffic, biased toward short counts so zero is reached often
    for (int i = 0; i < 3000; i++) begin
      logic [W-1:0] lv;
      if ($urandom_range(0, 1) == 0) lv = int_to_bcd(int'($urandom_range(0, 5)));
      else lv = W'($urandom);
      drive(($urandom_range(0, 99) != 0), ($urandom_range(0, 15) == 0), lv,
            ($urandom_range(0, 3) != 0));
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bcd_down_counter.md
# bcd_down_counter

Cascaded multi-digit BCD down counter (countdown timer) for the counter lab datapath. It is the decrementing counterpart of the decade up counter. A preset value is loaded, then counted down one step per `en` tick. A borrow ripples between 4-bit decade digits through a synchronous per-digit cell. A one-cycle `done` pulse is raised when the count reaches zero.

## Interface
Parameters:
- `DIGITS`, default 2: number of BCD decades; counter width is 4*DIGITS.

Ports:
- `clk`  in  1  single clock; all state changes on rising edge.
- `reset_n`  in  1  synchronous, active-low reset, sampled on rising edge of `clk`.
- `load`  in  1  load `load_value` and arm the counter.
- `load_value`  in  4*DIGITS  BCD preset, digit 0 in bits [3:0].
- `en`  in  1  count tick; decrement by one when running.
- `q`  out  4*DIGITS  current BCD count.
- `zero`  out  1  high while `q` equals all zero digits.
- `running`  out  1  high in state RUN.
- `done`  out  1  one-cycle pulse on the decrement that reaches zero.

## Operation
- Reset (`reset_n`=0 at edge): `q`=0, state IDLE, `running`=0, `done`=0, `zero`=1, stored reload value=0.
- States: IDLE, RUN, DONE.
  - IDLE/DONE: `en` ignored; `q` holds.
  - `load` in any state with nonzero `load_value`: `q`<=`load_value`, reload register<=`load_value`, next state RUN.
  - `load` with all-zero `load_value`: `q`<=0, next state DONE, no `done` pulse.
  - RUN, `en`=1, `q`>1: decrement `q` by one, stay in RUN.
  - RUN, `en`=1, `q`==1: `q`<=0, `done`<=1 for one cycle, next state DONE (see Configuration for the alternative).
- Digit arithmetic:
  - A digit decrements only when `en` is high and every lower digit is 0 (borrow in).
  - A digit at 0 with borrow in becomes 9 and propagates the borrow.
  - Example: 10 -> 09, 100 -> 099.
- Invalid BCD digit (>9) in `load_value` is clamped to 9 per digit at load time. `q` never holds a non-BCD digit.
- `load` and `en` in the same cycle: `load` wins and the tick is dropped.
- `zero` is combinational from `q`. `running` is decoded from the state.

## Timing
- `load` at edge k: `q`, `running` and `zero` reflect the new value after edge k, so they are visible in cycle k+1. Latency is 1 cycle.
- Each accepted `en` changes `q` at that edge. There is no pipelining, and the borrow chain fully resolves within one cycle for any DIGITS.
- `done` is registered. It is high exactly in the first cycle where `q`==0 after a decrement, then low.
- `reset_n` low mid-count overrides `load` and `en` at the same edge. Outputs return to reset values at that edge.

## Configuration
- `BCD_DOWN_RELOAD_EN` defined: periodic mode.
  - On `en` at `q`==1, `q`<=0, `done` pulses, and the state stays RUN.
  - The next `en` at `q`==0 restores `q` from the reload register.
  - The period is reload+1 ticks, with one `done` pulse per period.
  - Loading zero still goes to DONE.
- Not defined: one-shot mode as in Operation. The counter stays in DONE with `q`=0 until the next `load`.

## Structure
- Shared package `bcd_counter_pkg`:
  - `DIGIT_MAX` = 4'd9
  - `DIGIT_W` = 4
  - enum typedef `cnt_state_t` {IDLE, RUN, DONE}
- Sub-module `bcd_digit_down`: one decade register with inputs `dec` (borrow in), `ld` and `ld_val`, and output `borrow_out` (digit==0 && dec). It is instantiated DIGITS times via generate. The top-level FSM and reload register live in `bcd_down_counter`.

## Test plan
- Reset with `load`=1 and `en`=1 asserted -> `q`=00, `zero`=1, `running`=0, `done`=0 after the edge.
- Load 12, then 12 `en` ticks -> `q` sequence 11,10,09,...,01,00. `done` is high only in the cycle `q` first reads 00. State DONE. Further `en` keeps 00.
- Load 100 with DIGITS=3, one `en` -> `q`=099. Borrow ripples through two digits in one cycle.
- Load 0x5F (digit 0 invalid) -> `q`=59. Load 00 -> `zero`=1, state DONE, `done` never pulses.
- `load`=1 with 07 and `en`=1 in the same cycle while running at 03 -> `q`=07 and the tick is dropped. Deassert `reset_n` at `q`=04 -> `q`=00 and IDLE next cycle.
- With `BCD_DOWN_RELOAD_EN`: load 03, 8 ticks -> 02,01,00,03,02,01,00,03. `done` pulses twice and `running` stays 1 throughout.
